add_seq_slice: RTL and testbench

Multi-cycle, handshaked adder computing `{cout, sum} = a + b + cin` one SLICE-bit segment per clock, carry held in a register between segments. It is the responder end of the operand/result stream that the adder benches drive. Any upstream producer (bench, vector player, datapath controller) issues operand sets over a valid/ready request channel and collects `{cout, sum}` over a valid/ready response channel. It trades the combinational depth of the 16/32-bit adders for WIDTH/SLICE cycles of latency.

---
 rtl/add_seq_slice.sv | 126 ++++++++++++
 tb/tb_add_seq_slice.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_slice.sv
// Handshaked sequential adder: {cout, sum} = a + b + cin, one SLICE-bit segment per clock,
// with the inter-segment carry held in a register.
module add_seq_slice #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_SEG = CW'(N - 1);
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  int               sh_s;
  logic [SLICE-1:0] seg_a_s;
  logic [SLICE-1:0] seg_b_s;
  logic [SLICE:0]   seg_sum_s;

  // Segment datapath: select the current slice of each operand and add with the held carry.
  always_comb begin
    sh_s      = int'(cnt_q) * SLICE;
    seg_a_s   = SLICE'(a_q >> sh_s);
    seg_b_s   = SLICE'(b_q >> sh_s);
    seg_sum_s = {1'b0, seg_a_s} + {1'b0, seg_b_s} + {{SLICE{1'b0}}, carry_q};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Splice this segment's result into the sum without disturbing the other segments.
        sum_d   = (sum_q & ~(SEG_MASK << sh_s)) | (WIDTH'(seg_sum_s[SLICE-1:0]) << sh_s);
        carry_d = seg_sum_s[SLICE];
        if (cnt_q == LAST_SEG) begin
          cout_d  = seg_sum_s[SLICE];
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_slice.sv
// Self-checking bench for add_seq_slice: directed cases on the default build, then random
// streams on three configurations checked against plain a + b + cin arithmetic.
module tb_add_seq_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, out_ready;
  logic [31:0] a, b;
  int          sel;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
  logic [31:0] s0, s2;
  logic [15:0] s1;
  logic        in_ready_s, out_valid_s, cout_s;
  logic [31:0] sum_s;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  always_comb begin
    in_ready_s  = ir0;
    out_valid_s = ov0;
    cout_s      = co0;
    sum_s       = s0;
    if (sel == 1) begin
      in_ready_s  = ir1;
      out_valid_s = ov1;
      cout_s      = co1;
      sum_s       = {16'h0000, s1};
    end else if (sel == 2) begin
      in_ready_s  = ir2;
      out_valid_s = ov2;
      cout_s      = co2;
      sum_s       = s2;
    end
  end

  add_seq_slice #(.WIDTH(32), .SLICE(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .cin(cin),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0));

  add_seq_slice #(.WIDTH(16), .SLICE(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1));

  add_seq_slice #(.WIDTH(32), .SLICE(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b), .cin(cin),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cfg_w(input int s);
    return (s == 1) ? 16 : 32;
  endfunction

  function automatic int cfg_n(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  // Reference: unsigned (w+1)-bit result of a + b + cin.
  function automatic logic [63:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ({32'd0, x} & mask) + ({32'd0, y} & mask) + {63'd0, c};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    logic [63:0] e, mask;
    int          lat, w;
    w    = cfg_w(sel);
    mask = (64'd1 << w) - 64'd1;
    e    = ref_add(x, y, c, w);
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_ready_before"}, in_ready_s, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_ready_after_accept"}, in_ready_s, 0);
    lat = 0;
    while (!out_valid_s && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, cfg_n(sel));
    check({tag, "_sum"}, sum_s, e & mask);
    check({tag, "_cout"}, cout_s, (e >> w) & 64'd1);
    tick();
    check({tag, "_valid_after_take"}, out_valid_s, 0);
    check({tag, "_ready_after_take"}, in_ready_s, 1);
  endtask

  task automatic run_random(input int s, input string tag);
    logic [63:0] q[$];
    logic [63:0] e, e_acc, mask;
    int          n_acc = 0, n_rsp = 0, edge_n = 0, acc_edge = 0, cyc = 0, w, n;
    logic        prev_ov = 1'b0;
    bit          acc, rsp;
    sel = s;
    do_reset();
    w    = cfg_w(s);
    n    = cfg_n(s);
    mask = (64'd1 << w) - 64'd1;
    while ((n_acc < 100 || n_rsp < 100) && cyc < 5000) begin
      if (!in_valid) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        if (n_acc < 100 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          if ($urandom_range(0, 7) == 0) begin
            a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
          end
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc   = in_valid && in_ready_s;
      rsp   = out_valid_s && out_ready;
      e_acc = ref_add(a, b, cin, w);
      if (rsp) begin
        check({tag, "_result_expected"}, (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check({tag, "_sum"}, sum_s, e & mask);
          check({tag, "_cout"}, cout_s, (e >> w) & 64'd1);
        end
        n_rsp++;
      end
      tick();
      edge_n++;
      cyc++;
      if (acc) begin
        q.push_back(e_acc);
        n_acc++;
        acc_edge = edge_n;
        in_valid = 1'b0;
      end
      if (out_valid_s && !prev_ov) begin
        check({tag, "_latency"}, edge_n - acc_edge, n);
      end
      prev_ov = out_valid_s;
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, n_acc, 100);
    check({tag, "_responses"}, n_rsp, 100);
    check({tag, "_leftover"}, q.size(), 0);
  endtask

  initial begin
    int lat;
    sel = 0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0;
    a = 32'd0; b = 32'd0;
    do_reset();
    check("reset_in_ready", in_ready_s, 1);
    check("reset_out_valid", out_valid_s, 0);
    check("reset_sum", sum_s, 0);
    check("reset_cout", cout_s, 0);

    do_op("basic", 32'h0000_0001, 32'h0000_0002, 1'b0);
    do_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op("max_ops", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Backpressure: result must sit still while the producer churns its inputs.
    a = 32'h1234_5678; b = 32'h8765_4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_s && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("bp_sum", sum_s, 32'h9999_9999);
      check("bp_cout", cout_s, 0);
      check("bp_in_ready", in_ready_s, 0);
      check("bp_out_valid", out_valid_s, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_taken_out_valid", out_valid_s, 0);
    check("bp_taken_in_ready", in_ready_s, 1);

    // Reset two edges after accept, while segments are still being produced.
    a = 32'hDEAD_BEEF; b = 32'h0F0F_0F0F; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready_s, 1);
    check("rst_mid_out_valid", out_valid_s, 0);
    check("rst_mid_sum", sum_s, 0);
    check("rst_mid_cout", cout_s, 0);
    do_op("after_rst", 32'd5, 32'd7, 1'b0);

    run_random(0, "rand_w32_s8");
    run_random(1, "rand_w16_s4");
    run_random(2, "rand_w32_s32");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
